processor_control_unit: RTL
===========================

Name: processor_control_unit

Overview:
- Multi-cycle control FSM that sequences the processor datapath: 12-bit registers, a 16-entry register file, a 12-bit IR and an 8-bit immediate.
- Sits beside the datapath inside Processor.
- Takes the top-level start pulse and the decoded IR opcode.
- Drives every load, increment, bus-select, ALU and memory strobe until a HALT instruction or an illegal opcode ends the run.

Parameters:
- IR_width, 12, instruction register width; opcode is IR[11:8], immediate is IR[7:0].
- OPC_width, 4, opcode field width.
- MEM_LAT, 1, memory access wait cycles, minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces IDLE and clears all registered state.
- start  in  1  run request; sampled only in IDLE.
- opcode  in  OPC_width  IR[11:8]; valid from DECODE onward.
- z_flag  in  1  AC-zero flag from the datapath.
- bus_sel  out  3  bus source: 0 NONE, 1 PC, 2 MEM, 3 IMM, 4 AC, 5 R.
- alu_op  out  3  0 PASS, 1 ADD, 2 SUB.
- ar_ld, pc_ld, pc_inc, ir_ld, ac_ld, r_ld, z_ld  out  1 each  datapath register strobes.
- mem_rd, mem_wr  out  1 each  memory strobes.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on run end.
- illegal  out  1  sticky; set on an undefined opcode, cleared by the next accepted start.

Behaviour:
- Reset (reset=0): state=IDLE, wait counter=0, illegal=0. All outputs 0 immediately, including mid-instruction.
- Outputs are combinational from state, plus opcode in EXEC states. Any strobe not listed for a state is 0.
- IDLE: start=1 -> FETCH_A and clear illegal. start in any other state is ignored.
- FETCH_A: bus_sel=PC, ar_ld. -> FETCH_M.
- FETCH_M: mem_rd. Holds for MEM_LAT cycles, counted by the wait counter. -> FETCH_I.
- FETCH_I: mem_rd, bus_sel=MEM, ir_ld, pc_inc. -> DECODE.
- DECODE: no strobes. Branches on opcode:
  - 0 NOP -> FETCH_A.
  - 1 LDI: EXEC1 with bus_sel=IMM, alu_op=PASS, ac_ld, z_ld.
  - 2 LDM, 3 STM: EXEC1 with bus_sel=IMM, ar_ld; then EXEC_M.
    - LDM EXEC_M: mem_rd for MEM_LAT cycles, then EXEC2 with mem_rd, bus_sel=MEM, ac_ld, z_ld.
    - STM EXEC_M: bus_sel=AC, mem_wr held for MEM_LAT cycles; no EXEC2.
  - 4 ADD, 5 SUB: EXEC1 with bus_sel=R, alu_op=ADD/SUB, ac_ld, z_ld.
  - 6 MVR: EXEC1 with bus_sel=AC, r_ld.
  - 7 MVA: EXEC1 with bus_sel=R, alu_op=PASS, ac_ld, z_ld.
  - 8 JMP: EXEC1 with bus_sel=IMM, pc_ld.
  - 9 JPZ: EXEC1 with bus_sel=IMM, pc_ld only if z_flag=1 (sampled in EXEC1).
  - 15 HALT -> DONE.
  - 10-14 (undefined): set illegal, -> DONE.
- After the final EXEC state the FSM returns to FETCH_A.
- DONE: done=1, busy=1 for one cycle, then IDLE. start asserted in DONE is ignored.
- Cycle counts at MEM_LAT=1, start edge to the first FETCH_A of the next instruction:
  - fetch = 3 cycles; DECODE = 1.
  - LDI/ADD/SUB/MVR/MVA/JMP/JPZ: total 5.
  - LDM: total 7. STM: total 6. NOP: total 4.
- Wait counter width is clog2(MEM_LAT+1). It reloads on entry to FETCH_M/EXEC_M and never wraps.
- Exactly one bus source per cycle.
- pc_inc and pc_ld are never both 1 in the same cycle.
- mem_rd and mem_wr are never both 1 in the same cycle.

Decomposition:
- processor_pkg holds:
  - opcode localparams, OPC_NOP..OPC_HALT;
  - BUS_* and ALU_* codes;
  - the FSM state encoding: IDLE, FETCH_A, FETCH_M, FETCH_I, DECODE, EXEC1, EXEC_M, EXEC2, DONE.
- One sub-module, cu_wait_counter: load, decrement, zero flag. Shared by FETCH_M and EXEC_M.

Test Plan:
- Reset low for 2 cycles, then high; no start -> all outputs 0, busy=0 indefinitely.
- start pulse, opcode=1 (LDI), MEM_LAT=1:
  - cycle 1: ar_ld with bus_sel=1.
  - cycle 2: mem_rd.
  - cycle 3: ir_ld and pc_inc.
  - cycle 5: ac_ld with bus_sel=3.
  - cycle 6: ar_ld again.
- opcode=2 (LDM), MEM_LAT=3 -> mem_rd high for 3 cycles in FETCH_M and 3 in EXEC_M. ac_ld with bus_sel=2 in EXEC2; instruction length 11 cycles.
- opcode=9 with z_flag=0, then with z_flag=1 -> pc_ld=0 in the first case and pc_ld=1 with bus_sel=3 in the second.
- opcode=15 -> done=1 for exactly one cycle, busy falls the next cycle. start held high during DONE does not restart.
- opcode=12 -> illegal=1, done pulse; illegal stays 1 in IDLE and clears on the next start. Reset driven low during FETCH_M -> all strobes 0 in the same cycle, state IDLE.

Source files
------------

// File: rtl/processor_pkg.sv
// processor_pkg
// Shared encodings for the processor control unit: opcode values, bus-source
// and ALU-operation codes, and the control FSM state encoding.
package processor_pkg;

    // Opcode field values (IR[11:8])
    localparam logic [3:0] OPC_NOP  = 4'd0;
    localparam logic [3:0] OPC_LDI  = 4'd1;
    localparam logic [3:0] OPC_LDM  = 4'd2;
    localparam logic [3:0] OPC_STM  = 4'd3;
    localparam logic [3:0] OPC_ADD  = 4'd4;
    localparam logic [3:0] OPC_SUB  = 4'd5;
    localparam logic [3:0] OPC_MVR  = 4'd6;
    localparam logic [3:0] OPC_MVA  = 4'd7;
    localparam logic [3:0] OPC_JMP  = 4'd8;
    localparam logic [3:0] OPC_JPZ  = 4'd9;
    localparam logic [3:0] OPC_HALT = 4'd15;

    // Bus source select
    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd1;
    localparam logic [2:0] BUS_MEM  = 3'd2;
    localparam logic [2:0] BUS_IMM  = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_R    = 3'd5;

    // ALU operation
    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH_A = 4'd1,
        FETCH_M = 4'd2,
        FETCH_I = 4'd3,
        DECODE  = 4'd4,
        EXEC1   = 4'd5,
        EXEC_M  = 4'd6,
        EXEC2   = 4'd7,
        DONE    = 4'd8
    } state_t;

    // LDM and STM are the only instructions with a memory phase after EXEC1.
    function automatic logic is_mem_op(input logic [3:0] opc);
        return (opc == OPC_LDM) || (opc == OPC_STM);
    endfunction

endpackage

// File: rtl/cu_wait_counter.sv
// cu_wait_counter
// Memory wait-state counter shared by FETCH_M and EXEC_M. Loaded on entry to a
// memory state, decremented while in it; zero marks the last wait cycle.
// Ports:
//   clk, reset (async, active-low)
//   load, load_value : reload the count
//   dec              : count down by one (saturates at zero, never wraps)
//   zero             : count is zero
module cu_wait_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/processor_control_unit.sv
// processor_control_unit
// Multi-cycle control FSM sequencing the processor datapath from fetch through
// execute until HALT or an undefined opcode ends the run.
// Ports:
//   clk, reset (async, active-low), start (sampled in IDLE)
//   opcode  : IR[11:8], valid from DECODE onward
//   z_flag  : AC-zero flag from the datapath
//   bus_sel, alu_op, ar_ld, pc_ld, pc_inc, ir_ld, ac_ld, r_ld, z_ld,
//   mem_rd, mem_wr : datapath controls (combinational from state/opcode)
//   busy, done, illegal : run status
module processor_control_unit
    import processor_pkg::*;
#(
    parameter int IR_width  = 12,
    parameter int OPC_width = 4,
    parameter int MEM_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [OPC_width-1:0] opcode,
    input  logic                 z_flag,
    output logic [2:0]           bus_sel,
    output logic [2:0]           alu_op,
    output logic                 ar_ld,
    output logic                 pc_ld,
    output logic                 pc_inc,
    output logic                 ir_ld,
    output logic                 ac_ld,
    output logic                 r_ld,
    output logic                 z_ld,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal
);

    // A memory access always takes at least one wait cycle.
    localparam int LAT   = (MEM_LAT < 1) ? 1 : MEM_LAT;
    localparam int CNT_W = $clog2(LAT + 1);

    // The immediate occupies the IR bits below the opcode; a layout too narrow
    // for an 8-bit immediate elaborates this marker block.
    generate
        if (IR_width < OPC_width + 8) begin : g_ir_layout_too_narrow
        end
    endgenerate

    state_t      state_reg;
    logic        illegal_reg;
    logic [3:0]  opc;
    logic        wait_load;
    logic        wait_dec;
    logic        wait_zero;

    assign opc = 4'(opcode);

    // Reload on the cycle before entering a memory state so the count is
    // fresh on the first wait cycle.
    assign wait_load = (state_reg == FETCH_A) || ((state_reg == EXEC1) && is_mem_op(opc));
    assign wait_dec  = (state_reg == FETCH_M) || (state_reg == EXEC_M);

    cu_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait (
        .clk        (clk),
        .reset      (reset),
        .load       (wait_load),
        .load_value (CNT_W'(LAT - 1)),
        .dec        (wait_dec),
        .zero       (wait_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= FETCH_A;
                        illegal_reg <= 1'b0;
                    end
                end
                FETCH_A: state_reg <= FETCH_M;
                FETCH_M: if (wait_zero) state_reg <= FETCH_I;
                FETCH_I: state_reg <= DECODE;
                DECODE: begin
                    case (opc)
                        OPC_NOP:  state_reg <= FETCH_A;
                        OPC_HALT: state_reg <= DONE;
                        OPC_LDI, OPC_LDM, OPC_STM, OPC_ADD, OPC_SUB,
                        OPC_MVR, OPC_MVA, OPC_JMP, OPC_JPZ:
                                  state_reg <= EXEC1;
                        default: begin
                            illegal_reg <= 1'b1;
                            state_reg   <= DONE;
                        end
                    endcase
                end
                EXEC1:   state_reg <= is_mem_op(opc) ? EXEC_M : FETCH_A;
                EXEC_M: begin
                    if (wait_zero) begin
                        state_reg <= (opc == OPC_LDM) ? EXEC2 : FETCH_A;
                    end
                end
                EXEC2:   state_reg <= FETCH_A;
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus_sel = BUS_NONE;
        alu_op  = ALU_PASS;
        ar_ld   = 1'b0;
        pc_ld   = 1'b0;
        pc_inc  = 1'b0;
        ir_ld   = 1'b0;
        ac_ld   = 1'b0;
        r_ld    = 1'b0;
        z_ld    = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        case (state_reg)
            FETCH_A: begin
                bus_sel = BUS_PC;
                ar_ld   = 1'b1;
            end
            FETCH_M: mem_rd = 1'b1;
            FETCH_I: begin
                mem_rd  = 1'b1;
                bus_sel = BUS_MEM;
                ir_ld   = 1'b1;
                pc_inc  = 1'b1;
            end
            EXEC1: begin
                case (opc)
                    OPC_LDI: begin
                        bus_sel = BUS_IMM;
                        ac_ld   = 1'b1;
                        z_ld    = 1'b1;
                    end
                    OPC_LDM, OPC_STM: begin
                        bus_sel = BUS_IMM;
                        ar_ld   = 1'b1;
                    end
                    OPC_ADD, OPC_SUB: begin
                        bus_sel = BUS_R;
                        alu_op  = (opc == OPC_ADD) ? ALU_ADD : ALU_SUB;
                        ac_ld   = 1'b1;
                        z_ld    = 1'b1;
                    end
                    OPC_MVR: begin
                        bus_sel = BUS_AC;
                        r_ld    = 1'b1;
                    end
                    OPC_MVA: begin
                        bus_sel = BUS_R;
                        ac_ld   = 1'b1;
                        z_ld    = 1'b1;
                    end
                    OPC_JMP: begin
                        bus_sel = BUS_IMM;
                        pc_ld   = 1'b1;
                    end
                    OPC_JPZ: begin
                        bus_sel = BUS_IMM;
                        pc_ld   = z_flag;
                    end
                    default: ;
                endcase
            end
            EXEC_M: begin
                if (opc == OPC_STM) begin
                    bus_sel = BUS_AC;
                    mem_wr  = 1'b1;
                end else begin
                    mem_rd  = 1'b1;
                end
            end
            EXEC2: begin
                mem_rd  = 1'b1;
                bus_sel = BUS_MEM;
                ac_ld   = 1'b1;
                z_ld    = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign illegal = illegal_reg;

endmodule
